// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline constants: exception-code width, reset/flush PCs and ExcCode values.
package pipe_stage_reg_pkg;

   localparam int          EXC_W_DEF    = 5;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] FLUSH_PC_DEF = 32'h0000_4180;

   // ExcCode values; zero doubles as "no exception".
   localparam logic [4:0] EXC_NONE    = 5'd0;
   localparam logic [4:0] EXC_ADEL    = 5'd4;
   localparam logic [4:0] EXC_ADES    = 5'd5;
   localparam logic [4:0] EXC_SYSCALL = 5'd8;
   localparam logic [4:0] EXC_BP      = 5'd9;
   localparam logic [4:0] EXC_RI      = 5'd10;
   localparam logic [4:0] EXC_OV      = 5'd12;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One register slot: valid bit plus flat payload, with reset/clear/load/drop controls.
module stage_slot #(
   parameter int            PW      = 8,
   parameter logic [PW-1:0] RST_VAL = '0,
   parameter logic [PW-1:0] CLR_VAL = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          load,
   input  logic          drop,
   input  logic [PW-1:0] load_data,
   output logic          valid,
   output logic [PW-1:0] data
);

   // Priority reset > clear > load > drop; drop keeps the payload, only valid falls.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= RST_VAL;
      end else if (clear) begin
         valid <= 1'b0;
         data  <= CLR_VAL;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (drop) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer, flush, bubble and exception merge.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int          NFIELD   = 6,
   parameter int          W        = 32,
   parameter int          EXC_W    = EXC_W_DEF,
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] FLUSH_PC = FLUSH_PC_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  bubble,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_pc,
   input  logic [31:0]           in_instr,
   input  logic [NFIELD*W-1:0]   in_data,
   input  logic [EXC_W-1:0]      in_exc,
   input  logic                  in_bd,
   input  logic [EXC_W-1:0]      in_lexc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_pc,
   output logic [31:0]           out_instr,
   output logic [NFIELD*W-1:0]   out_data,
   output logic [EXC_W-1:0]      out_exc,
   output logic                  out_bd,
   output logic                  skid_full
);

   localparam int DW = NFIELD * W;
   localparam int PW = 64 + DW + EXC_W + 1;
   localparam logic [PW-1:0] MAIN_RST = {RESET_PC, {(PW-32){1'b0}}};
   localparam logic [PW-1:0] MAIN_CLR = {FLUSH_PC, {(PW-32){1'b0}}};

   // Handshake: a transfer happens on a rising edge where valid && ready are both high;
   // valid, once raised, holds its payload stable until the transfer; in_ready never
   // depends combinationally on out_ready.
   logic            main_v, skid_v;
   logic [PW-1:0]   main_q, skid_q;
   logic [PW-1:0]   entry, main_d;
   logic [EXC_W-1:0] exc_sel;
   logic            accept, consume;
   logic            main_load, skid_load;

   assign accept  = in_valid && in_ready;
   assign consume = main_v && out_ready;

   // Earliest stage wins: an exception arriving from upstream overrides the local one.
   assign exc_sel = (in_exc != '0) ? in_exc : in_lexc;
   assign entry   = bubble ? {in_pc, 32'h0, {DW{1'b0}}, {EXC_W{1'b0}}, in_bd}
                           : {in_pc, in_instr, in_data, exc_sel, in_bd};

   // Main refills from skid first (older entry), otherwise from the input.
   assign main_d    = skid_v ? skid_q : entry;
   assign main_load = (!main_v || consume) && (skid_v || accept);
   assign skid_load = accept && main_v && !consume;

   stage_slot #(.PW(PW), .RST_VAL(MAIN_RST), .CLR_VAL(MAIN_CLR)) u_main (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .load      (main_load),
      .drop      (consume),
      .load_data (main_d),
      .valid     (main_v),
      .data      (main_q)
   );

   stage_slot #(.PW(PW), .RST_VAL('0), .CLR_VAL('0)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .load      (skid_load),
      .drop      (consume),
      .load_data (entry),
      .valid     (skid_v),
      .data      (skid_q)
   );

   assign in_ready  = !skid_v;
   assign out_valid = main_v;
   assign skid_full = skid_v;
   assign {out_pc, out_instr, out_data, out_exc, out_bd} = main_q;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter NFIELD, default 6: number of W-bit payload fields carried besides PC/Instr.
REQ-002 SHALL have parameter W, default 32: width of each payload field.
REQ-003 SHALL have parameter EXC_W, default 5: exception-code width; 0 means no exception.
REQ-004 SHALL have parameter RESET_PC, default 32'h3000: PC output after reset.
REQ-005 SHALL have parameter FLUSH_PC, default 32'h4180: PC output after flush.
REQ-006 SHALL have port clk, input, 1: clock, all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port flush, input, 1: synchronous kill of all held entries (exception/eret).
REQ-009 SHALL have port bubble, input, 1: entry accepted this cycle becomes a NOP that keeps its PC and BD.
REQ-010 SHALL have ports in_valid (input, 1) and in_ready (output, 1): upstream handshake.
REQ-011 SHALL have ports in_pc (input, 32), in_instr (input, 32), in_data (input, NFIELD*W), in_exc (input, EXC_W), in_bd (input, 1), in_lexc (input, EXC_W): in_lexc is the exception raised locally by this stage.
REQ-012 SHALL have ports out_valid (input 1 -> output, 1) and out_ready (input, 1): downstream handshake.
REQ-013 SHALL have ports out_pc (output, 32), out_instr (output, 32), out_data (output, NFIELD*W), out_exc (output, EXC_W), out_bd (output, 1), skid_full (output, 1).

Function
REQ-014 SHALL hold two slots: main (drives out_*) and skid; out_valid = main valid; skid_full = skid valid.
REQ-015 SHALL drive in_ready = !skid_full, from a register only (no combinational path from out_ready).
REQ-016 SHALL accept an entry when in_valid && in_ready; an entry is consumed when out_valid && out_ready.
REQ-017 SHALL give 1-cycle latency: an entry accepted at edge N appears on out_* after edge N when main is empty or being consumed.
REQ-018 SHALL place the accepted entry in skid when main is valid and not being consumed.
REQ-019 SHALL, on consumption with skid valid, move skid into main and, in the same edge, place any accepted entry in skid.
REQ-020 SHALL sustain one entry per cycle when out_ready stays high; no entry is lost or duplicated.
REQ-021 SHALL keep out_* stable while out_valid && !out_ready.
REQ-022 SHALL store exc as in_exc if nonzero, else in_lexc (earliest stage wins).
REQ-023 SHALL, when bubble is high with an accept, store instr=0, data=0, exc=0 and keep pc and bd from the inputs, with valid=1.
REQ-024 SHALL, on flush, clear both valid bits, ignore in_valid that edge, and set out_pc=FLUSH_PC, out_instr=0, out_data=0, out_exc=0, out_bd=0.
REQ-025 SHALL give priority reset > flush > normal operation; bubble without accept has no effect.
REQ-026 SHALL keep in_ready high after a flush.
REQ-027 SHALL treat a simultaneous consume and accept on a full skid as impossible, because in_ready is low.

Reset
REQ-028 SHALL, on reset, set out_valid=0, skid_full=0, in_ready=1, out_pc=RESET_PC, out_instr=0, out_data=0, out_exc=0, out_bd=0.
REQ-029 SHALL discard any entry in flight, main or skid, on a reset asserted mid-operation.

Structure
REQ-030 SHALL take EXC_W, RESET_PC, FLUSH_PC defaults and the ExcCode constants from the shared constants package.
REQ-031 SHALL instantiate one sub-module, stage_slot: a single register slot holding valid plus payload, with load/clear, used twice (main, skid).

Verification
REQ-032 SHALL cover: reset, then idle -> out_pc=0x3000, out_valid=0, in_ready=1.
REQ-033 SHALL cover streaming: out_ready=1, in_pc 0x3000,0x3004,0x3008 on consecutive cycles -> same PCs on out_pc one cycle later each, skid_full stays 0.
REQ-034 SHALL cover backpressure: out_ready=0, accept 0x3000 then 0x3004 -> skid_full=1, in_ready=0; out_ready=1 -> 0x3000 then 0x3004 delivered in order, in_ready=1 again.
REQ-035 SHALL cover flush with both slots full -> next cycle out_valid=0, out_pc=0x4180, in_ready=1; the two entries never appear.
REQ-036 SHALL cover bubble with in_pc=0x3010, in_instr=0x8C010000, in_bd=1 -> out_pc=0x3010, out_instr=0, out_bd=1, out_exc=0.
REQ-037 SHALL cover exception merge: in_exc=0, in_lexc=4 -> out_exc=4; in_exc=10, in_lexc=4 -> out_exc=10.
